// File: rtl/mccoy_pkg.sv
// Shared definitions for the exec_control sequencer and its ALU:
// widths, opcode encodings and FSM states.
package mccoy_pkg;

   localparam int DATA_W_DEF = 6;
   localparam int PC_W_DEF   = 6;

   localparam logic [2:0] OP_NOP = 3'b000;
   localparam logic [2:0] OP_LDI = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b011;
   localparam logic [2:0] OP_AND = 3'b100;
   localparam logic [2:0] OP_XOR = 3'b101;
   localparam logic [2:0] OP_ST  = 3'b110;
   localparam logic [2:0] OP_EXT = 3'b111;

   localparam logic [1:0] SUB_LD   = 2'b00;
   localparam logic [1:0] SUB_SHL  = 2'b01;
   localparam logic [1:0] SUB_SHR  = 2'b10;
   localparam logic [1:0] SUB_HALT = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_WRITE  = 3'd3,
      ST_HALT   = 3'd4
   } state_e;

   function automatic logic is_halt(input logic [7:0] ir);
      return (ir[7:5] == OP_EXT) && (ir[4:3] == SUB_HALT);
   endfunction

endpackage

// File: rtl/mccoy_alu.sv
// Combinational ALU: computes the new accumulator value and carry for one
// instruction, plus the write enables telling the sequencer what to commit.
module mccoy_alu
   import mccoy_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic [2:0]        op_i,
   input  logic [1:0]        sub_i,
   input  logic [DATA_W-1:0] x8_i,
   input  logic [DATA_W-1:0] reg_i,
   input  logic [4:0]        imm_i,
   output logic [DATA_W-1:0] result_o,
   output logic              carry_o,
   output logic              carry_we_o,
   output logic              x8_we_o
);

   logic [DATA_W:0] sum_s;

   assign sum_s = {1'b0, x8_i} + {1'b0, reg_i};

   always_comb begin
      result_o   = x8_i;
      carry_o    = 1'b0;
      carry_we_o = 1'b0;
      x8_we_o    = 1'b0;
      case (op_i)
         OP_LDI: begin
            result_o = {{(DATA_W-5){1'b0}}, imm_i};
            x8_we_o  = 1'b1;
         end
         OP_ADD: begin
            result_o   = sum_s[DATA_W-1:0];
            carry_o    = sum_s[DATA_W];
            carry_we_o = 1'b1;
            x8_we_o    = 1'b1;
         end
         OP_SUB: begin
            result_o   = x8_i - reg_i;
            carry_o    = (x8_i < reg_i);
            carry_we_o = 1'b1;
            x8_we_o    = 1'b1;
         end
         OP_AND: begin
            result_o = x8_i & reg_i;
            x8_we_o  = 1'b1;
         end
         OP_XOR: begin
            result_o = x8_i ^ reg_i;
            x8_we_o  = 1'b1;
         end
         OP_EXT: begin
            case (sub_i)
               SUB_LD: begin
                  result_o = reg_i;
                  x8_we_o  = 1'b1;
               end
               SUB_SHL: begin
                  result_o   = {x8_i[DATA_W-2:0], 1'b0};
                  carry_o    = x8_i[DATA_W-1];
                  carry_we_o = 1'b1;
                  x8_we_o    = 1'b1;
               end
               SUB_SHR: begin
                  result_o   = {1'b0, x8_i[DATA_W-1:1]};
                  carry_o    = x8_i[0];
                  carry_we_o = 1'b1;
                  x8_we_o    = 1'b1;
               end
               default: begin
                  result_o = x8_i;
               end
            endcase
         end
         default: begin
            result_o = x8_i;
         end
      endcase
   end

endmodule

// File: rtl/exec_control.sv
// Sequencing/execute stage in front of the x0-x7 register file: fetches one
// instruction per handshake, executes it against x8 and owns pc and halt.
module exec_control
   import mccoy_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int PC_W   = PC_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        instr,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic [DATA_W-1:0] reg_out,
   output logic [2:0]        reg_addr,
   output logic              write_reg,
   output logic [DATA_W-1:0] x8,
   output logic [PC_W-1:0]   pc,
   output logic              zero,
   output logic              carry,
   output logic              halted
);

   state_e              state_q, state_d;
   logic [7:0]          ir_q, ir_d;
   logic [PC_W-1:0]     pc_q, pc_d;
   logic [DATA_W-1:0]   x8_q, x8_d;
   logic                zero_q, zero_d;
   logic                carry_q, carry_d;

   logic [DATA_W-1:0]   alu_result_s;
   logic                alu_carry_s;
   logic                alu_carry_we_s;
   logic                alu_x8_we_s;

   mccoy_alu #(.DATA_W(DATA_W)) u_alu (
      .op_i       (ir_q[7:5]),
      .sub_i      (ir_q[4:3]),
      .x8_i       (x8_q),
      .reg_i      (reg_out),
      .imm_i      (ir_q[4:0]),
      .result_o   (alu_result_s),
      .carry_o    (alu_carry_s),
      .carry_we_o (alu_carry_we_s),
      .x8_we_o    (alu_x8_we_s)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (instr_valid) state_d = ST_DECODE;
            else             state_d = ST_IDLE;
         end
         ST_DECODE: begin
            if (ir_q[7:5] == OP_ST) state_d = ST_WRITE;
            else if (is_halt(ir_q)) state_d = ST_HALT;
            else                    state_d = ST_EXEC;
         end
         ST_EXEC:  state_d = ST_IDLE;
         ST_WRITE: state_d = ST_IDLE;
         ST_HALT:  state_d = ST_HALT;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Outputs decode only registered state, so they hold steady across the negedge.
   always_comb begin
      instr_ready = 1'b0;
      reg_addr    = 3'd0;
      write_reg   = 1'b0;
      halted      = 1'b0;
      case (state_q)
         ST_IDLE:   instr_ready = 1'b1;
         ST_DECODE: reg_addr = ir_q[2:0];
         ST_EXEC:   reg_addr = ir_q[2:0];
         ST_WRITE: begin
            reg_addr  = ir_q[2:0];
            write_reg = 1'b1;
         end
         ST_HALT:   halted = 1'b1;
         default:   instr_ready = 1'b0;
      endcase
   end

   always_comb begin
      ir_d    = ir_q;
      pc_d    = pc_q;
      x8_d    = x8_q;
      zero_d  = zero_q;
      carry_d = carry_q;
      if (state_q == ST_IDLE && instr_valid) begin
         ir_d = instr;
         pc_d = pc_q + PC_W'(1);
      end else if (state_q == ST_EXEC) begin
         if (alu_x8_we_s) begin
            x8_d   = alu_result_s;
            zero_d = (alu_result_s == '0);
         end else begin
            x8_d = x8_q;
         end
         if (alu_carry_we_s) carry_d = alu_carry_s;
         else                carry_d = carry_q;
      end else begin
         ir_d = ir_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ir_q    <= 8'd0;
         pc_q    <= '0;
         x8_q    <= '0;
         zero_q  <= 1'b0;
         carry_q <= 1'b0;
      end else begin
         ir_q    <= ir_d;
         pc_q    <= pc_d;
         x8_q    <= x8_d;
         zero_q  <= zero_d;
         carry_q <= carry_d;
      end
   end

   assign x8    = x8_q;
   assign pc    = pc_q;
   assign zero  = zero_q;
   assign carry = carry_q;

endmodule

// File: tb/tb_exec_control.sv
// Self-checking bench for exec_control: a behavioural register file on the
// negedge write strobe, directed scenarios and randomized instruction streams.
module tb_exec_control;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] instr;
   logic       instr_valid;
   logic       instr_ready;
   logic [5:0] reg_out;
   logic [2:0] reg_addr;
   logic       write_reg;
   logic [5:0] x8;
   logic [5:0] pc;
   logic       zero;
   logic       carry;
   logic       halted;

   exec_control dut (
      .clk         (clk),
      .reset       (reset),
      .instr       (instr),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .reg_out     (reg_out),
      .reg_addr    (reg_addr),
      .write_reg   (write_reg),
      .x8          (x8),
      .pc          (pc),
      .zero        (zero),
      .carry       (carry),
      .halted      (halted)
   );

   always #5 clk = ~clk;

   // Register file model: x0 reads zero, writes land on the negedge.
   logic [5:0] rf [8];
   logic       pre_we = 1'b0;
   logic [2:0] pre_addr = 3'd0;
   logic [5:0] pre_data = 6'd0;

   assign reg_out = (reg_addr == 3'd0) ? 6'd0 : rf[reg_addr];

   always @(negedge clk) begin
      if (pre_we) rf[pre_addr] <= pre_data;
      else if (write_reg && reg_addr != 3'd0) rf[reg_addr] <= x8;
   end

   int n_cmp = 0;
   int n_err = 0;

   int m_x8, m_pc;
   bit m_zero, m_carry, m_halted;
   int m_regs [8];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic preset(input int a, input int d);
      pre_addr = 3'(a);
      pre_data = 6'(d);
      pre_we   = 1'b1;
      @(negedge clk);
      #1 pre_we = 1'b0;
      m_regs[a] = (a == 0) ? 0 : d;
   endtask

   // Reference model: architectural effect of one instruction.
   task automatic model_exec(input logic [7:0] ins);
      int a, r, rs, res;
      bit we;
      a   = m_x8;
      rs  = int'(ins[2:0]);
      r   = (rs == 0) ? 0 : m_regs[rs];
      res = a;
      we  = 1'b0;
      m_pc = (m_pc + 1) % 64;
      case (int'(ins[7:5]))
         1: begin res = int'(ins[4:0]); we = 1'b1; end
         2: begin m_carry = (a + r) > 63; res = (a + r) % 64; we = 1'b1; end
         3: begin m_carry = a < r; res = (a - r + 64) % 64; we = 1'b1; end
         4: begin res = a & r; we = 1'b1; end
         5: begin res = a ^ r; we = 1'b1; end
         6: if (rs != 0) m_regs[rs] = a;
         7: case (int'(ins[4:3]))
               0: begin res = r; we = 1'b1; end
               1: begin m_carry = a >= 32; res = (a * 2) % 64; we = 1'b1; end
               2: begin m_carry = (a % 2) == 1; res = a / 2; we = 1'b1; end
               default: m_halted = 1'b1;
            endcase
         default: ;
      endcase
      if (we) begin
         m_x8   = res;
         m_zero = (res == 0);
      end
   endtask

   task automatic do_reset();
      instr_valid = 1'b0;
      instr       = 8'd0;
      reset       = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      m_x8 = 0; m_pc = 0; m_zero = 1'b0; m_carry = 1'b0; m_halted = 1'b0;
      chk("rst_x8", x8, 0);
      chk("rst_pc", pc, 0);
      chk("rst_zero", zero, 0);
      chk("rst_carry", carry, 0);
      chk("rst_halted", halted, 0);
      chk("rst_wr", write_reg, 0);
      chk("rst_addr", reg_addr, 0);
      chk("rst_ready", instr_ready, 1);
   endtask

   // One full instruction: accept, DECODE, EXEC/WRITE, then architectural check.
   task automatic issue(input logic [7:0] ins);
      chk("acc_ready", instr_ready, 1);
      instr       = ins;
      instr_valid = 1'b1;
      @(negedge clk);
      instr_valid = 1'b0;
      instr       = 8'($urandom);
      chk("dec_ready", instr_ready, 0);
      chk("dec_addr", reg_addr, ins[2:0]);
      chk("dec_wr", write_reg, 0);
      chk("dec_pc", pc, (m_pc + 1) % 64);
      @(negedge clk);
      chk("ex_x8_old", x8, m_x8);
      model_exec(ins);
      if (m_halted) begin
         chk("halt_flag", halted, 1);
         chk("halt_ready", instr_ready, 0);
         chk("halt_addr", reg_addr, 0);
         chk("halt_pc", pc, m_pc);
         return;
      end
      chk("ex_addr", reg_addr, ins[2:0]);
      chk("ex_wr", write_reg, (ins[7:5] == 3'b110) ? 1 : 0);
      @(negedge clk);
      chk("res_x8", x8, m_x8);
      chk("res_zero", zero, m_zero);
      chk("res_carry", carry, m_carry);
      chk("res_pc", pc, m_pc);
      chk("res_ready", instr_ready, 1);
      chk("res_wr", write_reg, 0);
      chk("res_halted", halted, 0);
   endtask

   initial begin
      logic [7:0] ins;
      int acc;
      instr = 8'd0;
      instr_valid = 1'b0;
      reset = 1'b1;
      for (int i = 0; i < 8; i++) m_regs[i] = 0;
      do_reset();
      for (int i = 1; i < 8; i++) preset(i, 0);
      @(negedge clk);

      // LDI 5, then store/load round trip through x3
      issue(8'h25);
      issue(8'h3F);
      issue(8'hC3);
      issue(8'h20);
      issue(8'hE3);
      chk("ld_x3", x8, 31);

      // ADD/SUB carry and borrow, XOR to zero keeps carry
      preset(3, 63);
      preset(4, 31);
      issue(8'h43);
      issue(8'h63);
      issue(8'hA4);
      chk("xor_zero", zero, 1);
      issue(8'hC0);

      // Randomized stream against the model
      for (int i = 1; i < 8; i++) preset(i, int'($urandom_range(63, 0)));
      for (int n = 0; n < 60; n++) begin
         ins = 8'($urandom);
         if (ins[7:3] == 5'b11111) ins[4:3] = 2'b01;
         issue(ins);
         if (n == 30) preset(int'($urandom_range(7, 1)), int'($urandom_range(63, 0)));
      end

      // instr_valid held high: one acceptance every third cycle, pc wraps
      do_reset();
      instr = 8'd0;
      instr_valid = 1'b1;
      acc = 0;
      for (int i = 0; i < 195; i++) begin
         if (instr_ready && instr_valid) acc++;
         @(negedge clk);
      end
      instr_valid = 1'b0;
      chk("nop_accepts", acc, 65);
      chk("nop_pc_wrap", pc, 1);
      chk("nop_ready", instr_ready, 1);
      m_pc = 1;

      // HALT, then further valid instructions are ignored
      issue(8'h25);
      issue(8'hF8);
      instr = 8'h25;
      instr_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("hold_halted", halted, 1);
         chk("hold_ready", instr_ready, 0);
         chk("hold_pc", pc, m_pc);
         chk("hold_x8", x8, m_x8);
      end
      do_reset();

      // Reset on the edge into WRITE: no strobe, x5 keeps its value
      preset(5, 17);
      issue(8'h29);
      instr = 8'hC5;
      instr_valid = 1'b1;
      @(negedge clk);
      instr_valid = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      chk("rw_wr", write_reg, 0);
      chk("rw_ready", instr_ready, 1);
      chk("rw_x8", x8, 0);
      chk("rw_pc", pc, 0);
      reset = 1'b0;
      m_x8 = 0; m_pc = 0; m_zero = 1'b0; m_carry = 1'b0; m_halted = 1'b0;
      @(negedge clk);
      chk("rw_wr_after", write_reg, 0);
      issue(8'hE5);
      chk("rw_x5_kept", x8, 17);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
